// File: rtl/vga_bitmap_pkg.sv
// Shared constants and helpers for the VGA bitmap renderer.
// Fixed pipeline depth excludes the ROM read latency.
package vga_bitmap_pkg;

    localparam int RGB_W_DEFAULT = 3;
    localparam int BASE_LAT      = 3;

    localparam logic [RGB_W_DEFAULT-1:0] BLACK = '0;
    localparam logic [RGB_W_DEFAULT-1:0] WHITE = '1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// Fixed-depth shift register with asynchronous clear, used to
// align side-band data with the ROM read latency.
module vga_pipe_delay
    import vga_bitmap_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_bitmap_render.sv
// 1-bpp scaled/mirrored bitmap window; c1/c2 to rgb latency is BASE_LAT+ROM_LAT.
// Define VGA_BITMAP_TRANSP_EN to add rgb_under for a transparent overlay.
module vga_bitmap_render
    import vga_bitmap_pkg::*;
#(
    parameter int CNT_W   = 11,
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int ROM_AW  = clog2(IMG_W * IMG_H / 8),
    parameter int ROM_LAT = 1,
    parameter int RGB_W   = RGB_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  c1,
    input  logic [CNT_W-1:0]  c2,
    input  logic [CNT_W-1:0]  cfg_x0,
    input  logic [CNT_W-1:0]  cfg_y0,
    input  logic [1:0]        cfg_scale,
    input  logic              cfg_mirror,
    input  logic [RGB_W-1:0]  cfg_fg,
    input  logic [RGB_W-1:0]  cfg_bg,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
`ifdef VGA_BITMAP_TRANSP_EN
    input  logic [RGB_W-1:0]  rgb_under,
`endif
    output logic [RGB_W-1:0]  rgb
);

    localparam int XW      = clog2(IMG_W);
    localparam int YW      = clog2(IMG_H);
    localparam int DW      = CNT_W + 1;
    localparam int WW      = CNT_W + 4;
    localparam int LAT     = BASE_LAT + ROM_LAT;
    localparam int ALIGN_D = LAT - BASE_LAT;
    localparam int ALN_W   = 4 + 2 * RGB_W;

    localparam logic [RGB_W-1:0] OFF = {RGB_W{BLACK[0]}};
    localparam logic [RGB_W-1:0] ON  = {RGB_W{WHITE[0]}};

    logic [CNT_W-1:0]  x0_q, x0_d, y0_q, y0_d;
    logic [1:0]        scale_q, scale_d;
    logic              mirror_q, mirror_d;
    logic [RGB_W-1:0]  fg_q, fg_d, bg_q, bg_d;
    logic              cap;

    logic [DW-1:0]     dx, dy;
    logic [WW-1:0]     lim_x, lim_y;
    logic [XW-1:0]     px_q, px_d;
    logic [YW-1:0]     py_q, py_d;
    logic              valid0_q, valid0_d;
    logic [RGB_W-1:0]  fg0_q, fg0_d, bg0_q, bg0_d;

    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              valid1_q, valid1_d;
    logic [2:0]        bitsel1_q, bitsel1_d;
    logic [RGB_W-1:0]  fg1_q, fg1_d, bg1_q, bg1_d;

    logic [ALN_W-1:0]  aln_in, aln_out;
    logic              al_valid, al_bit;
    logic [2:0]        al_bitsel;
    logic [RGB_W-1:0]  al_fg, al_bg;
    logic [RGB_W-1:0]  rgb_q, rgb_d;

    // Config is only taken at the frame origin so a frame never tears.
    always_comb begin
        cap      = (c1 == '0) && (c2 == '0);
        x0_d     = cap ? cfg_x0 : x0_q;
        y0_d     = cap ? cfg_y0 : y0_q;
        scale_d  = cap ? cfg_scale : scale_q;
        mirror_d = cap ? cfg_mirror : mirror_q;
        fg_d     = cap ? cfg_fg : fg_q;
        bg_d     = cap ? cfg_bg : bg_q;
    end

    // The extra sign bit flags c < origin; wide limits stop wrap-around.
    always_comb begin
        dx       = {1'b0, c1} - {1'b0, x0_q};
        dy       = {1'b0, c2} - {1'b0, y0_q};
        lim_x    = WW'(IMG_W) << scale_q;
        lim_y    = WW'(IMG_H) << scale_q;
        valid0_d = !dx[DW-1] && !dy[DW-1] &&
                   (WW'(dx) < lim_x) && (WW'(dy) < lim_y);
        px_d     = XW'(dx >> scale_q);
        py_d     = YW'(dy >> scale_q);
        if (mirror_q) px_d = ~px_d;
        fg0_d    = fg_q;
        bg0_d    = bg_q;
    end

    always_comb begin
        rom_addr_d = rom_addr_q;
        if (valid0_q) rom_addr_d = ROM_AW'({py_q, px_q[XW-1:3]});
        valid1_d  = valid0_q;
        bitsel1_d = ~px_q[2:0];
        fg1_d     = fg0_q;
        bg1_d     = bg0_q;
    end

    assign aln_in = {valid1_q, bitsel1_q, fg1_q, bg1_q};

    vga_pipe_delay #(
        .WIDTH (ALN_W),
        .DEPTH (ALIGN_D)
    ) u_align (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (aln_in),
        .q     (aln_out)
    );

    assign {al_valid, al_bitsel, al_fg, al_bg} = aln_out;

`ifdef VGA_BITMAP_TRANSP_EN
    localparam int UNDER_D = LAT - 1;
    logic [RGB_W-1:0] under_dly;

    vga_pipe_delay #(
        .WIDTH (RGB_W),
        .DEPTH (UNDER_D)
    ) u_under (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rgb_under),
        .q     (under_dly)
    );
`endif

    always_comb begin
        al_bit = rom_data[al_bitsel];
`ifdef VGA_BITMAP_TRANSP_EN
        rgb_d = under_dly;
        if (al_valid && al_bit) rgb_d = al_fg;
`else
        rgb_d = OFF;
        if (al_valid) rgb_d = al_bit ? al_fg : al_bg;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q       <= '0;
            y0_q       <= '0;
            scale_q    <= '0;
            mirror_q   <= 1'b0;
            fg_q       <= ON;
            bg_q       <= OFF;
            px_q       <= '0;
            py_q       <= '0;
            valid0_q   <= 1'b0;
            fg0_q      <= '0;
            bg0_q      <= '0;
            rom_addr_q <= '0;
            valid1_q   <= 1'b0;
            bitsel1_q  <= '0;
            fg1_q      <= '0;
            bg1_q      <= '0;
            rgb_q      <= OFF;
        end else begin
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            scale_q    <= scale_d;
            mirror_q   <= mirror_d;
            fg_q       <= fg_d;
            bg_q       <= bg_d;
            px_q       <= px_d;
            py_q       <= py_d;
            valid0_q   <= valid0_d;
            fg0_q      <= fg0_d;
            bg0_q      <= bg0_d;
            rom_addr_q <= rom_addr_d;
            valid1_q   <= valid1_d;
            bitsel1_q  <= bitsel1_d;
            fg1_q      <= fg1_d;
            bg1_q      <= bg1_d;
            rgb_q      <= rgb_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign rgb      = rgb_q;

endmodule

// File: tb/tb_vga_bitmap_render.sv
// Bench for vga_bitmap_render: directed window cases plus random stimulus
// against a pixel-level model of the bitmap window.
module tb_vga_bitmap_render;

    localparam int MAXP = 8192;
    localparam int IDLE = 2047;
`ifdef VGA_BITMAP_TRANSP_EN
    localparam int OUT_V = 1;
`else
    localparam int OUT_V = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] c1 = '0, c2 = '0;
    logic [10:0] cfg_x0 = '0, cfg_y0 = '0;
    logic [1:0]  cfg_scale = '0;
    logic        cfg_mirror = 1'b0;
    logic [2:0]  cfg_fg = 3'b111, cfg_bg = '0;
    logic [8:0]  rom_addr;
    logic [7:0]  rom_data = '0;
    logic [2:0]  rgb;
    logic [7:0]  rom_mem [512];
`ifdef VGA_BITMAP_TRANSP_EN
    logic [2:0]  rgb_under = '0;
`endif

    int   m_x0, m_y0, m_scale, m_mirror, m_fg, m_bg;
    int   ex_rgb [MAXP];
    int   ex_hold [MAXP];
    int   cur = -1;
    int   nchk = 0, nfail = 0;
    bit   rst_req = 1'b1;
    bit   rand_cfg = 1'b0;
    bit   under_fix = 1'b1;
    int   under_val = 1;

    vga_bitmap_render dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .c1         (c1),
        .c2         (c2),
        .cfg_x0     (cfg_x0),
        .cfg_y0     (cfg_y0),
        .cfg_scale  (cfg_scale),
        .cfg_mirror (cfg_mirror),
        .cfg_fg     (cfg_fg),
        .cfg_bg     (cfg_bg),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
`ifdef VGA_BITMAP_TRANSP_EN
        .rgb_under  (rgb_under),
`endif
        .rgb        (rgb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One pixel per clock: drive it and record what it must produce.
    task automatic step(input int cx, input int cy);
        int dx, dy, x, y, ad, under, e, prev;
        bit v, b;
        @(negedge clk);
        rst_n = !rst_req;
        if (rand_cfg) begin
            cfg_x0 = ($urandom_range(0, 3) == 0) ?
                     11'($urandom_range(1900, 2047)) : 11'($urandom_range(0, 300));
            cfg_y0 = 11'($urandom_range(0, 300));
            cfg_scale = 2'($urandom_range(0, 3));
            cfg_mirror = 1'($urandom_range(0, 1));
            cfg_fg = 3'($urandom);
            cfg_bg = 3'($urandom);
        end
        c1 = 11'(cx);
        c2 = 11'(cy);
        under = under_fix ? under_val : int'($urandom_range(0, 7));
`ifdef VGA_BITMAP_TRANSP_EN
        rgb_under = 3'(under);
`endif
        cur++;
        prev = (cur > 0) ? ex_hold[cur-1] : 0;
        if (!rst_n) begin
            ex_rgb[cur] = 0;
            ex_hold[cur] = 0;
            m_x0 = 0; m_y0 = 0; m_scale = 0; m_mirror = 0;
            m_fg = 7; m_bg = 0;
        end else begin
            dx = cx - m_x0;
            dy = cy - m_y0;
            v = dx >= 0 && dy >= 0 && dx < (64 << m_scale) && dy < (64 << m_scale);
`ifdef VGA_BITMAP_TRANSP_EN
            e = under;
`else
            e = 0;
`endif
            ad = prev;
            if (v) begin
                x = dx >> m_scale;
                y = dy >> m_scale;
                if (m_mirror != 0) x = 63 - x;
                ad = y * 8 + x / 8;
                b = rom_mem[ad][7 - x % 8];
`ifdef VGA_BITMAP_TRANSP_EN
                e = b ? m_fg : under;
`else
                e = b ? m_fg : m_bg;
`endif
            end
            ex_rgb[cur] = e;
            ex_hold[cur] = ad;
            if (cx == 0 && cy == 0) begin
                m_x0 = int'(cfg_x0); m_y0 = int'(cfg_y0);
                m_scale = int'(cfg_scale); m_mirror = int'(cfg_mirror);
                m_fg = int'(cfg_fg); m_bg = int'(cfg_bg);
            end
        end
    endtask

    // Hand-computed expectations: address two edges on, colour four edges on.
    task automatic pix_chk(input string nm, input int cx, input int cy,
                           input int ea, input int ergb);
        step(cx, cy);
        step(IDLE, IDLE);
        @(posedge clk);
        #2;
        chk({nm, "_addr"}, int'(rom_addr), ea);
        step(IDLE, IDLE);
        step(IDLE, IDLE);
        @(posedge clk);
        #2;
        chk({nm, "_rgb"}, int'(rgb), ergb);
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            chk("rst_rgb", int'(rgb), 0);
            chk("rst_addr", int'(rom_addr), 0);
        end else if (cur >= 3) begin
            chk("rgb", int'(rgb), ex_rgb[cur-3]);
            chk("rom_addr", int'(rom_addr), ex_hold[cur-1]);
        end
    end

    initial begin
        int r;
        for (int i = 0; i < 512; i++) rom_mem[i] = 8'h00;
        repeat (4) step(IDLE, IDLE);
        rst_req = 1'b0;
        repeat (4) step(IDLE, IDLE);

        cfg_x0 = 11'd100; cfg_y0 = 11'd50; cfg_scale = 2'd0;
        cfg_mirror = 1'b0; cfg_fg = 3'b111; cfg_bg = 3'b001;
        step(IDLE, IDLE);
        step(0, 0);
        step(IDLE, IDLE);
        rom_mem[9] = 8'h01;
        rom_mem[7] = 8'h01;
        pix_chk("hit_fg", 115, 51, 9, 7);
        rom_mem[9] = 8'hFE;
        pix_chk("hit_bg", 115, 51, 9, 1);
        pix_chk("edge_r", 163, 50, 7, 7);
        pix_chk("out_r", 164, 50, 7, OUT_V);
        pix_chk("out_l", 99, 50, 7, OUT_V);
        pix_chk("out_b", 115, 114, 7, OUT_V);

        cfg_scale = 2'd1;
        step(0, 0);
        step(IDLE, IDLE);
        rom_mem[9] = 8'h20;
        pix_chk("scl", 120, 53, 9, 7);
        pix_chk("scl_in", 227, 50, 7, 7);
        pix_chk("scl_out", 228, 50, 7, OUT_V);

        cfg_scale = 2'd0;
        cfg_mirror = 1'b1;
        step(0, 0);
        step(IDLE, IDLE);
        pix_chk("mir", 100, 50, 7, 7);

        cfg_mirror = 1'b0;
        cfg_x0 = 11'd500;
        pix_chk("shd_hold", 100, 50, 7, 7);
        step(0, 0);
        step(IDLE, IDLE);
        pix_chk("shd_new", 100, 50, 7, OUT_V);

        cfg_x0 = 11'd100;
        step(0, 0);
        step(IDLE, IDLE);
`ifdef VGA_BITMAP_TRANSP_EN
        rom_mem[9] = 8'hFE;
        under_val = 2;
        pix_chk("transp", 115, 51, 9, 2);
        under_val = 1;
`endif

        rom_mem[9] = 8'h01;
        repeat (6) step(115, 51);
        rst_req = 1'b1;
        step(115, 51);
        #1;
        chk("rst_async_rgb", int'(rgb), 0);
        chk("rst_async_addr", int'(rom_addr), 0);
        repeat (3) step(115, 51);
        rst_req = 1'b0;
        repeat (6) step(115, 51);

        repeat (5) step(IDLE, IDLE);
        for (int i = 0; i < 512; i++) rom_mem[i] = 8'($urandom);
        under_fix = 1'b0;
        rand_cfg = 1'b1;
        repeat (3000) begin
            r = int'($urandom_range(0, 15));
            if (r == 0) step(0, 0);
            else if (r < 12) step(int'($urandom_range(0, 700)), int'($urandom_range(0, 600)));
            else step(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
        end
        rand_cfg = 1'b0;
        repeat (6) step(IDLE, IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/vga_bitmap_render.md
Name: vga_bitmap_render

Overview:
Parametrised 1-bpp bitmap renderer for the VGA path. Takes the timing generator's column/row counters, maps them into a movable, integer-scalable, optionally mirrored window, and fetches packed 8-pixel bytes from a synchronous ROM. Outputs one registered RGB pixel per clock at a fixed, documented latency. Sits between the sync/counter generator and the DAC pins, replacing fixed-size, fixed-colour monochrome renderers.

Parameters:
CNT_W, 11, width of column/row counters c1/c2.
IMG_W, 64, bitmap width in pixels; power of two, >= 8.
IMG_H, 64, bitmap height in pixels; power of two.
ROM_AW, clog2(IMG_W*IMG_H/8), ROM address width (default 9).
ROM_LAT, 1, ROM read latency in cycles (>= 1).
RGB_W, 3, colour width.

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
c1  in  CNT_W  current column counter
c2  in  CNT_W  current row counter
cfg_x0  in  CNT_W  window left edge
cfg_y0  in  CNT_W  window top edge
cfg_scale  in  2  scale = 1<<cfg_scale (1x/2x/4x/8x)
cfg_mirror  in  1  horizontal mirror
cfg_fg  in  RGB_W  colour for pixel bit 1
cfg_bg  in  RGB_W  colour for pixel bit 0 inside window
rom_addr  out  ROM_AW  byte address to ROM
rom_data  in  8  ROM byte, valid ROM_LAT cycles after rom_addr
rgb  out  RGB_W  registered pixel colour

Behaviour:
- Reset: rgb=0, rom_addr=0, all pipeline valid flags 0; shadow config x0=0, y0=0, scale=0, mirror=0, fg=all ones, bg=0. Reset is asynchronous and takes effect mid-frame: rgb goes to 0 immediately.
- Shadow config: cfg_* are captured on the clock edge where c1==0 && c2==0. Pixel (0,0) uses the previous shadow values; new values apply from the next pixel. No mid-frame tearing.
- Stage 0 (edge k+1): dx=c1-x0 and dy=c2-y0, computed in CNT_W+1 bits (sign bit catches c<x0).
  - valid0 = dx,dy non-negative, dx < IMG_W<<scale, dy < IMG_H<<scale. Comparisons are done in CNT_W+4 bits, so windows extending past the counter range clip without wrap.
  - x = dx>>scale, y = dy>>scale.
  - If mirror: x = IMG_W-1-x.
  - Registers x, y, valid0.
- Stage 1 (edge k+2):
  - If valid0: rom_addr = y*(IMG_W/8) + x[XW-1:3], a shift/concatenation with no multiplier. Otherwise rom_addr holds its last value.
  - bitsel = 7-x[2:0]; bit 7 of the byte is the leftmost pixel.
  - valid1 and bitsel are registered.
- Alignment: valid1 and bitsel are delayed ROM_LAT cycles to meet rom_data.
- Output (edge k+3+ROM_LAT): rgb = !valid ? 0 : (rom_data[bitsel] ? fg : bg).
- Total latency from c1/c2 to rgb = 3+ROM_LAT (4 by default). The caller delays syncs to match.
- Back-to-back pixels have full throughput, no stalls. Scale/mirror changes are frame-synchronous only.

Optional Feature:
VGA_BITMAP_TRANSP_EN
- Defined: adds input rgb_under[RGB_W], presented aligned with c1/c2. It is internally delayed 2+ROM_LAT cycles. Where the bitmap bit is 0, or the pixel is outside the window, rgb = delayed rgb_under instead of bg/0. Gives a transparent overlay for chaining renderers.
- Undefined: no port; behaviour as above.

Decomposition:
- Package vga_bitmap_pkg: clog2 function, RGB_W default, colour constants (BLACK=0, WHITE=all ones), pipeline-depth constant BASE_LAT=3.
- Sub-module vga_pipe_delay (parameters WIDTH, DEPTH; async-reset shift register). Used for valid/bitsel alignment and the rgb_under delay.

Test Plan:
- Reset mid-frame: assert rst_n=0 while a pixel is in window -> rgb=0 same cycle, rom_addr=0; after release, first 4 cycles rgb=0.
- Window hit: x0=100, y0=50, scale=0, fg=3'b111, bg=3'b001; c1=115, c2=51 -> rom_addr=9 at k+2; rom_data=8'h01 -> rgb=3'b111 at k+4; rom_data=8'hFE -> rgb=3'b001.
- Edges: c1=163 (x=63), c2=50 -> in window; c1=164 -> rgb=0; c1=99 -> rgb=0; c2=114 -> rgb=0.
- Scale: scale=1; c1=120, c2=53 -> x=10, y=1, rom_addr=9, bit 5 selected; c1=227 inside, c1=228 outside.
- Mirror: mirror=1, c1=100, c2=50 -> x=63, rom_addr=7, bit 0 selected.
- Shadow: change cfg_x0 mid-frame -> window unchanged until after c1=c2=0. With VGA_BITMAP_TRANSP_EN, rgb_under=3'b010 on bit-0 pixels -> rgb=3'b010.
